mybus_fifo: RTL and testbench
=============================

Name: mybus_fifo

Overview:
- 4-bit point-to-point bus channel: a synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Carries the 4-bit `foo` payload from a producer to a consumer and decouples the two by buffering and backpressure.
- Sits between bus endpoints inside a single clock domain.

Parameters:
- WIDTH, 4, payload width in bits (`foo` width).
- DEPTH, 4, number of storage entries; must be a power of two and at least 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  FIFO can accept a word this cycle.
- in_foo  input  WIDTH  producer payload.
- out_valid  output  1  head word is available.
- out_ready  input  1  consumer accepts the head word this cycle.
- out_foo  output  WIDTH  head payload.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately with no clock edge needed):
  - read and write pointers = 0, count = 0.
  - empty=1, full=0, in_ready=1, out_valid=0, out_foo=0.
  - Storage contents are don't-care.
  - Reset asserted mid-transfer discards all stored words. The first edge after rst deasserts behaves as normal operation.
- Handshake outputs:
  - in_ready = !full.
  - out_valid = !empty.
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Data transfers only on a rising edge where its handshake is true.
- Payload:
  - out_foo combinationally shows the entry at the read pointer whenever out_valid=1.
  - out_foo is driven 0 when empty.
- Push: write in_foo at the write pointer; write pointer +1, wrapping modulo DEPTH.
- Pop: read pointer +1, wrapping modulo DEPTH.
- count update each edge:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on both or neither.
- Latency and ordering:
  - A word pushed into an empty FIFO is visible on out_valid/out_foo on the next cycle. There is no combinational in-to-out bypass.
  - Words exit strictly in arrival order; no loss, no duplication.
- Boundary cases:
  - Full: in_ready=0, so in_valid is ignored, even if out_ready=1 in the same cycle. A freed slot shows as in_ready=1 on the following cycle.
  - Empty: out_ready is ignored; count never underflows.
  - Simultaneous push and pop at 0 < count < DEPTH: count is unchanged and both pointers advance.
  - Pointer wrap-around is seamless across arbitrarily long streams.
- Input stability:
  - in_foo and out_ready may change freely while their valid/ready partner is low.
  - No protocol obligation is placed on the producer after a stall. The FIFO only samples in_foo on a push edge.
- No X propagates to outputs after reset, regardless of in_foo content.

Test Plan:
- Reset check: assert rst mid-stream with count=3 → immediately count=0, empty=1, out_valid=0, out_foo=0, in_ready=1.
- Single word: push 4'hA into the empty FIFO with out_ready=0 → next cycle out_valid=1, out_foo=4'hA, count=1. Then pulse out_ready → empty=1, count=0.
- Fill, then full pop and push:
  - Push 4'h1, 4'h2, 4'h3, 4'h4 with out_ready=0 → full=1, count=4, in_ready=0.
  - Drive in_valid=1 with in_foo=4'hF for 3 cycles → count stays 4 and the 4'hF word is not stored.
  - Drain → outputs 1,2,3,4 in order.
  - With full=1, in_valid=1 (in_foo=4'h9) and out_ready=1 in the same cycle → head 4'h1 pops, 4'h9 is not accepted, count=3, and in_ready=1 on the next cycle.
- Simultaneous push and pop at count=2 → count stays 2 and order is preserved.
- Wrap-around stream:
  - Drive 20 consecutive words 0..F,0..3 with out_ready toggling pseudo-randomly.
  - Consumer receives the exact same sequence; count never exceeds 4 or goes negative.
  - Repeat with out_ready=1 constantly → sustained throughput of 1 word per cycle after the 1-cycle latency.
- Underflow: out_ready=1 held for 5 cycles while empty → count stays 0, out_valid=0, out_foo=0.

Source files
------------

// File: rtl/mybus_fifo.sv
// First-word-fall-through FIFO carrying the foo payload between two valid/ready endpoints.
// Head word is shown combinationally; pushes become visible one cycle later (no bypass).
module mybus_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_foo,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_foo,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             push, pop;

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_reg;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Forced to zero when empty so stale or never-written entries never leak out.
  assign out_foo   = empty ? '0 : mem_reg[rd_ptr_reg];

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is left unreset; its contents are unobservable until written.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= in_foo;
  end

endmodule

// File: tb/tb_mybus_fifo.sv
// Bench for mybus_fifo: directed boundary cases plus randomized traffic against a queue model.
module tb_mybus_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_foo = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_foo;
  logic [2:0] count;
  logic       full;
  logic       empty;

  int n_cmp = 0;
  int n_bad = 0;
  int q[$];          // reference contents, head at index 0
  int recv[$];       // words observed leaving the DUT in a stream test
  int dut_pops;

  mybus_fifo #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_foo(in_foo),
    .out_valid(out_valid), .out_ready(out_ready), .out_foo(out_foo),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (got running, want finished)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the model's view of the current state.
  task automatic check_outputs(input string where);
    int n;
    n = q.size();
    chk({where, ":count"},     8'(count),     8'(n));
    chk({where, ":full"},      8'(full),      8'(n == 4));
    chk({where, ":empty"},     8'(empty),     8'(n == 0));
    chk({where, ":in_ready"},  8'(in_ready),  8'(n != 4));
    chk({where, ":out_valid"}, 8'(out_valid), 8'(n != 0));
    chk({where, ":out_foo"},   8'(out_foo),   8'((n == 0) ? 0 : q[0]));
  endtask

  // One clock cycle: apply inputs, check mid-cycle, clock, update the model.
  task automatic cycle(input string where, input logic iv, input logic [3:0] fo, input logic ordy);
    bit do_push, do_pop;
    in_valid  = iv;
    in_foo    = fo;
    out_ready = ordy;
    #1;
    check_outputs(where);
    if (out_valid === 1'b1 && ordy) begin
      dut_pops++;
      recv.push_back(int'(out_foo));
    end
    do_push = iv && (q.size() < 4);
    do_pop  = ordy && (q.size() > 0);
    @(posedge clk);
    if (do_pop) begin
      $display("%s: pop  %h (count %0d)", where, q[0], q.size() - 1 + int'(do_push));
      void'(q.pop_front());
    end
    if (do_push) begin
      q.push_back(int'(fo));
      $display("%s: push %h (count %0d)", where, fo, q.size());
    end
    #1;
  endtask

  // Feed words 0..F,0..3, holding each until accepted; rnd_ready selects random backpressure.
  task automatic stream(input string where, input bit rnd_ready);
    int idx, guard;
    logic ordy;
    idx = 0;
    guard = 0;
    recv.delete();
    while ((idx < 20 || q.size() > 0) && guard < 400) begin
      ordy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx < 20) begin
        if (q.size() < 4) begin
          cycle(where, 1'b1, 4'(idx), ordy);
          idx++;
        end else begin
          cycle(where, 1'b1, 4'(idx), ordy);
        end
      end else begin
        cycle(where, 1'b0, 4'($urandom_range(0, 15)), ordy);
      end
      guard++;
    end
    chk({where, ":finished"}, 8'(guard < 400), 8'(1));
    chk({where, ":recv_len"}, 8'(recv.size()), 8'(20));
    for (int i = 0; i < recv.size() && i < 20; i++)
      chk({where, ":order"}, 8'(recv[i]), 8'(i % 16));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;

    // Single word with one-cycle latency
    cycle("single", 1'b1, 4'hA, 1'b0);
    cycle("single", 1'b0, 4'h0, 1'b0);
    cycle("single", 1'b0, 4'h5, 1'b1);
    cycle("single", 1'b0, 4'h0, 1'b0);

    // Fill, ignore pushes while full, drain in order
    for (int i = 1; i <= 4; i++) cycle("fill", 1'b1, 4'(i), 1'b0);
    repeat (3) cycle("full_hold", 1'b1, 4'hF, 1'b0);
    repeat (4) cycle("drain", 1'b0, 4'h0, 1'b1);

    // Full with push and pop in the same cycle: only the pop happens
    for (int i = 1; i <= 4; i++) cycle("refill", 1'b1, 4'(i), 1'b0);
    cycle("full_both", 1'b1, 4'h9, 1'b1);
    cycle("after_full", 1'b0, 4'h0, 1'b0);
    repeat (3) cycle("drain2", 1'b0, 4'h0, 1'b1);

    // Simultaneous push and pop at count 2
    cycle("sim", 1'b1, 4'h6, 1'b0);
    cycle("sim", 1'b1, 4'h7, 1'b0);
    for (int i = 0; i < 4; i++) cycle("sim_both", 1'b1, 4'(8 + i), 1'b1);
    repeat (3) cycle("sim_drain", 1'b0, 4'h0, 1'b1);

    // Asynchronous reset mid-stream with three words stored
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 4'(3 + i), 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    check_outputs("async_rst");
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("post_rst");

    // Wrap-around streams
    stream("wrap_rnd", 1'b1);
    dut_pops = 0;
    stream("wrap_full_rate", 1'b0);
    chk("throughput_pops", 8'(dut_pops), 8'(20));

    // Underflow
    repeat (5) cycle("underflow", 1'b0, 4'($urandom_range(0, 15)), 1'b1);

    // Random soak
    for (int i = 0; i < 200; i++)
      cycle("soak", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    while (q.size() > 0) cycle("soak_drain", 1'b0, 4'h0, 1'b1);
    cycle("final", 1'b0, 4'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
